// File: rtl/softmax_feeder_pkg.sv
// Shared types and width helpers for the softmax row-to-block feeder.
package softmax_feeder_pkg;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    DRAIN     = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_t;

  // Width of the presented row index (one spare bit above the row count).
  function automatic int row_idx_width(input int rows);
    return $clog2(rows) + 1;
  endfunction

  // Width needed to address one entry of a row bank.
  function automatic int bank_addr_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // Width of the tile counter.
  function automatic int tile_cnt_width(input int tiles);
    return (tiles > 1) ? $clog2(tiles) : 1;
  endfunction

endpackage

// File: rtl/softmax_row_bank.sv
// Row bank: ROWS full softmax rows held in registers, one write port and a
// combinational read mux. Contents are not reset; every row is rewritten
// before it is ever presented downstream.
module softmax_row_bank
  import softmax_feeder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int COL   = 256,
  parameter int ROWS  = 4,
  parameter int AW    = bank_addr_width(ROWS)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_idx,
  input  logic [WIDTH*COL-1:0] wr_data,
  input  logic [AW-1:0]        rd_idx,
  output logic [WIDTH*COL-1:0] rd_data
);

  logic [WIDTH*COL-1:0] mem_q [ROWS];

  // Capture an accepted row into its slot.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  // Present the selected row without a register stage.
  always_comb begin
    rd_data = mem_q[rd_idx];
  end

endmodule

// File: rtl/softmax_r2b_feeder.sv
// Softmax row-to-block feeder: collects a bank of softmax rows, presents them
// one at a time to the converter, and releases the bank on buffer_done.
// Optional build macro SOFTMAX_FEEDER_PINGPONG_EN adds a second bank so that
// filling one bank overlaps draining the other.
module softmax_r2b_feeder
  import softmax_feeder_pkg::*;
#(
  parameter int WIDTH             = 16,
  parameter int COL               = 256,
  parameter int TOTAL_SOFTMAX_ROW = 4,
  parameter int TOTAL_TILES       = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         en,
  input  logic                                         s_valid,
  input  logic [WIDTH*COL-1:0]                         s_data,
  output logic                                         s_ready,
  output logic                                         r2b_in_valid,
  output logic [row_idx_width(TOTAL_SOFTMAX_ROW)-1:0]  r2b_row_idx,
  output logic [WIDTH*COL-1:0]                         r2b_in_data,
  input  logic                                         r2b_slice_done,
  input  logic                                         r2b_buffer_done,
  output logic                                         tile_done,
  output logic                                         all_done
);

  localparam int IDX_W = row_idx_width(TOTAL_SOFTMAX_ROW);
  localparam int AW    = bank_addr_width(TOTAL_SOFTMAX_ROW);
  localparam int TC_W  = tile_cnt_width(TOTAL_TILES);
  localparam logic [AW-1:0]    LAST_WR   = AW'(TOTAL_SOFTMAX_ROW - 1);
  localparam logic [IDX_W-1:0] LAST_RD   = IDX_W'(TOTAL_SOFTMAX_ROW - 1);
  localparam logic [TC_W-1:0]  LAST_TILE = TC_W'(TOTAL_TILES - 1);

  feeder_state_t    state_q, state_d;
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] row_idx_q, row_idx_d;
  logic [TC_W-1:0]  tile_cnt_q, tile_cnt_d;
  logic             tile_done_q, tile_done_d;
  logic             all_done_q, all_done_d;
  logic             beat, fill_last, release_bank;

`ifdef SOFTMAX_FEEDER_PINGPONG_EN
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;
`endif

  // Next-state, counters, bank bookkeeping and done pulses.
  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    row_idx_d    = row_idx_q;
    tile_cnt_d   = tile_cnt_q;
    tile_done_d  = 1'b0;
    all_done_d   = 1'b0;
    release_bank = 1'b0;
`ifdef SOFTMAX_FEEDER_PINGPONG_EN
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    s_ready   = en & ~full_q[wr_bank_q];
`else
    s_ready   = en & (state_q == FILL);
`endif
    beat      = s_valid & s_ready;
    fill_last = beat & (wr_idx_q == LAST_WR);

    if (en) begin
      if (beat) wr_idx_d = fill_last ? '0 : wr_idx_q + 1'b1;
`ifdef SOFTMAX_FEEDER_PINGPONG_EN
      if (fill_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
`endif
      case (state_q)
        FILL: begin
`ifdef SOFTMAX_FEEDER_PINGPONG_EN
          if (full_q[rd_bank_q] || (fill_last && (wr_bank_q == rd_bank_q))) state_d = DRAIN;
`else
          if (fill_last) state_d = DRAIN;
`endif
        end
        DRAIN: begin
          if (r2b_slice_done) begin
            if (row_idx_q == LAST_RD) begin
              row_idx_d = '0;
              if (r2b_buffer_done) release_bank = 1'b1;
              else                 state_d      = WAIT_DONE;
            end else begin
              row_idx_d = row_idx_q + 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          if (r2b_buffer_done) release_bank = 1'b1;
        end
        default: state_d = FILL;
      endcase

      if (release_bank) begin
        tile_done_d = 1'b1;
        all_done_d  = (tile_cnt_q == LAST_TILE);
        tile_cnt_d  = (tile_cnt_q == LAST_TILE) ? '0 : tile_cnt_q + 1'b1;
`ifdef SOFTMAX_FEEDER_PINGPONG_EN
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        state_d = (full_q[~rd_bank_q] || (fill_last && (wr_bank_q != rd_bank_q))) ? DRAIN : FILL;
`else
        state_d = FILL;
`endif
      end
    end
  end

  // Control registers; reset returns to an empty FILL state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      row_idx_q   <= '0;
      tile_cnt_q  <= '0;
      tile_done_q <= 1'b0;
      all_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      row_idx_q   <= row_idx_d;
      tile_cnt_q  <= tile_cnt_d;
      tile_done_q <= tile_done_d;
      all_done_q  <= all_done_d;
    end
  end

  assign r2b_in_valid = (state_q == DRAIN);
  assign r2b_row_idx  = row_idx_q;
  assign tile_done    = tile_done_q;
  assign all_done     = all_done_q;

`ifdef SOFTMAX_FEEDER_PINGPONG_EN
  logic [WIDTH*COL-1:0] rd_data0, rd_data1;

  // Bank ownership registers for the fill and drain sides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

  softmax_row_bank #(.WIDTH(WIDTH), .COL(COL), .ROWS(TOTAL_SOFTMAX_ROW), .AW(AW)) u_bank0 (
    .clk(clk), .wr_en(beat & ~wr_bank_q), .wr_idx(wr_idx_q), .wr_data(s_data),
    .rd_idx(row_idx_q[AW-1:0]), .rd_data(rd_data0)
  );
  softmax_row_bank #(.WIDTH(WIDTH), .COL(COL), .ROWS(TOTAL_SOFTMAX_ROW), .AW(AW)) u_bank1 (
    .clk(clk), .wr_en(beat & wr_bank_q), .wr_idx(wr_idx_q), .wr_data(s_data),
    .rd_idx(row_idx_q[AW-1:0]), .rd_data(rd_data1)
  );
  assign r2b_in_data = rd_bank_q ? rd_data1 : rd_data0;
`else
  softmax_row_bank #(.WIDTH(WIDTH), .COL(COL), .ROWS(TOTAL_SOFTMAX_ROW), .AW(AW)) u_bank (
    .clk(clk), .wr_en(beat), .wr_idx(wr_idx_q), .wr_data(s_data),
    .rd_idx(row_idx_q[AW-1:0]), .rd_data(r2b_in_data)
  );
`endif

endmodule

// File: tb/tb_softmax_r2b_feeder.sv
// Self-checking bench for softmax_r2b_feeder (WIDTH=16, COL=4, 4 rows, 2 tiles).
// The reference model tracks accepted rows as queues: rows being filled and
// complete banks awaiting the converter.
module tb_softmax_r2b_feeder;

  localparam int WIDTH = 16;
  localparam int COL   = 4;
  localparam int N     = 4;
  localparam int TILES = 2;
  localparam int DW    = WIDTH * COL;
`ifdef SOFTMAX_FEEDER_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef logic [DW-1:0] row_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          r2b_in_valid;
  logic [2:0]    r2b_row_idx;
  logic [DW-1:0] r2b_in_data;
  logic          r2b_slice_done = 1'b0;
  logic          r2b_buffer_done = 1'b0;
  logic          tile_done;
  logic          all_done;

  softmax_r2b_feeder #(.WIDTH(WIDTH), .COL(COL), .TOTAL_SOFTMAX_ROW(N), .TOTAL_TILES(TILES)) dut (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .r2b_in_valid(r2b_in_valid), .r2b_row_idx(r2b_row_idx), .r2b_in_data(r2b_in_data),
    .r2b_slice_done(r2b_slice_done), .r2b_buffer_done(r2b_buffer_done),
    .tile_done(tile_done), .all_done(all_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  row_t fill_rows[$];
  row_t bank_rows[$];
  int   m_sliced = 0;
  int   m_tile = 0;
  bit   m_tile_done = 0;
  bit   m_all_done = 0;

  task automatic modelReset();
    fill_rows.delete();
    bank_rows.delete();
    m_sliced    = 0;
    m_tile      = 0;
    m_tile_done = 0;
    m_all_done  = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs of that cycle.
  task automatic modelUpdate(input bit e, input bit sv, input row_t d, input bit sl, input bit bd);
    bit can_fill, drn, wt, rel;
    m_tile_done = 0;
    m_all_done  = 0;
    if (!e) return;
    can_fill = (bank_rows.size() / N) < CAP;
    drn      = (bank_rows.size() > 0) && (m_sliced < N);
    wt       = (bank_rows.size() > 0) && (m_sliced == N);
    rel      = 0;
    if (drn && sl) begin
      m_sliced++;
      if (m_sliced == N && bd) rel = 1;
    end else if (wt && bd) begin
      rel = 1;
    end
    if (can_fill && sv) begin
      fill_rows.push_back(d);
      if (fill_rows.size() == N) begin
        foreach (fill_rows[k]) bank_rows.push_back(fill_rows[k]);
        fill_rows.delete();
      end
    end
    if (rel) begin
      m_tile_done = 1;
      m_all_done  = (m_tile == TILES - 1);
      m_tile      = (m_tile + 1) % TILES;
      repeat (N) void'(bank_rows.pop_front());
      m_sliced = 0;
    end
  endtask

  task automatic checkVal(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic checkOutput();
    bit drn;
    drn = (bank_rows.size() > 0) && (m_sliced < N);
    checkVal("s_ready", DW'(s_ready), DW'(en && ((bank_rows.size() / N) < CAP)));
    checkVal("in_valid", DW'(r2b_in_valid), DW'(drn));
    checkVal("row_idx", DW'(r2b_row_idx), DW'((m_sliced < N) ? m_sliced : 0));
    checkVal("tile_done", DW'(tile_done), DW'(m_tile_done));
    checkVal("all_done", DW'(all_done), DW'(m_all_done));
    if (drn) checkVal("in_data", r2b_in_data, bank_rows[m_sliced]);
  endtask

  // Drive one cycle of inputs, check mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input bit e, input bit sv, input row_t d, input bit sl, input bit bd);
    en              = e;
    s_valid         = sv;
    s_data          = d;
    r2b_slice_done  = sl;
    r2b_buffer_done = bd;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelUpdate(e, sv, d, sl, bd);
    #1;
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    en = 1'b1; s_valid = 1'b0; r2b_slice_done = 1'b0; r2b_buffer_done = 1'b0;
    modelReset();
    repeat (cycles) begin
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  function automatic row_t randRow();
    return {$urandom, $urandom};
  endfunction

  task automatic fillRandom();
    for (int k = 0; k < N; k++) applyStimulus(1, 1, randRow(), 0, 0);
  endtask

  initial begin
    // Power-on reset.
    doReset(2);

    // Reset mid-fill discards the partial bank.
    applyStimulus(1, 1, randRow(), 0, 0);
    applyStimulus(1, 1, randRow(), 0, 0);
    doReset(3);

    // Directed rows 1..4 with slice_done every third cycle; upstream keeps offering.
    for (int k = 1; k <= N; k++) applyStimulus(1, 1, {COL{16'(k)}}, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(1, 1, randRow(), (i % 3) == 2, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, '0, 0, i == 4);
    applyStimulus(1, 0, '0, 0, 0);

    // Second tile: all_done expected with its tile_done.
    fillRandom();
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, '0, (i % 2) == 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, '0, 0, i == 4);
    applyStimulus(1, 0, '0, 0, 0);

    // Enable dropped mid-drain with pulses present.
    fillRandom();
    applyStimulus(1, 0, '0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, randRow(), 1, 1);
    applyStimulus(1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0, 1, 0);
    applyStimulus(1, 0, '0, 0, 1);
    applyStimulus(1, 0, '0, 0, 0);

    // buffer_done coincident with the final slice_done.
    fillRandom();
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0, 1, 0);
    applyStimulus(1, 0, '0, 1, 1);
    applyStimulus(1, 0, '0, 0, 0);
    applyStimulus(1, 0, '0, 0, 0);

    // Continuous upstream with a fast converter.
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, randRow(), 1, i >= 7);

    // Randomised traffic including enable gaps and stray pulses.
    for (int i = 0; i < 120; i++)
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, randRow(),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
